// File: rtl/tree_loader_pkg.sv
// Shared defaults, derived widths and loader state encoding for the tree feature loader.
package tree_loader_pkg;

  localparam int unsigned FEAT_W    = 51;
  localparam int unsigned IN_W      = 8;
  localparam int unsigned NUM_TREES = 5;
  localparam int unsigned SETTLE    = 2;

  localparam int unsigned BEATS = (FEAT_W + IN_W - 1) / IN_W;
  localparam int unsigned CNT_W = $clog2(NUM_TREES + 1);

  typedef enum logic [1:0] {
    StFill   = 2'd0,
    StSettle = 2'd1,
    StOut    = 2'd2
  } state_e;

endpackage

// File: rtl/tree_vote_majority.sv
// Combinational popcount of the tree decision bits and strict-majority compare.
module tree_vote_majority #(
  parameter int unsigned NUM_TREES = tree_loader_pkg::NUM_TREES,
  parameter int unsigned CNT_W     = $clog2(NUM_TREES + 1)
) (
  input  logic [NUM_TREES-1:0] trees,
  output logic [CNT_W-1:0]     count,
  output logic                 vote
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_TREES; i++) begin
      count = count + CNT_W'(trees[i]);
    end
    vote = (count > CNT_W'(NUM_TREES / 2));
  end

endmodule

// File: rtl/tree_feature_loader.sv
// Assembles feature vectors from a byte stream, waits for the trees to settle,
// then returns their majority vote on a valid/ready handshake.
module tree_feature_loader #(
  parameter int unsigned FEAT_W    = tree_loader_pkg::FEAT_W,
  parameter int unsigned IN_W      = tree_loader_pkg::IN_W,
  parameter int unsigned NUM_TREES = tree_loader_pkg::NUM_TREES,
  parameter int unsigned SETTLE    = tree_loader_pkg::SETTLE,
  parameter int unsigned CNT_W     = $clog2(NUM_TREES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_W-1:0]      s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [FEAT_W-1:0]    feat_o,
  input  logic [NUM_TREES-1:0] tree_i,
  output logic                 m_vote,
  output logic [CNT_W-1:0]     m_count,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy
);

  import tree_loader_pkg::*;

  localparam int unsigned Beats = (FEAT_W + IN_W - 1) / IN_W;
  localparam int unsigned BufW  = Beats * IN_W;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned SetW  = 4;

  state_e            state_q, state_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic [BufW-1:0]   shift_q, shift_d;
  logic [SetW-1:0]   settle_q, settle_d;
  logic [FEAT_W-1:0] feat_q, feat_d;
  logic              vote_q, vote_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;

  logic [CNT_W-1:0]  tree_count;
  logic              tree_vote;
  logic              accept;
  logic              last_beat;

  tree_vote_majority #(
    .NUM_TREES(NUM_TREES),
    .CNT_W    (CNT_W)
  ) u_vote (
    .trees(tree_i),
    .count(tree_count),
    .vote (tree_vote)
  );

  assign accept    = (state_q == StFill) && s_valid && ready_q;
  assign last_beat = (beat_q == BeatW'(Beats - 1));

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    shift_d  = shift_q;
    settle_d = settle_q;
    feat_d   = feat_q;
    vote_d   = vote_q;
    count_d  = count_q;
    valid_d  = valid_q;
    case (state_q)
      StFill: begin
        if (accept) begin
          for (int k = 0; k < Beats; k++) begin
            if (beat_q == BeatW'(k)) shift_d[k*IN_W +: IN_W] = s_data;
          end
          if (last_beat) begin
            // Bits of the final beat above FEAT_W never reach the trees.
            feat_d   = shift_d[FEAT_W-1:0];
            beat_d   = '0;
            settle_d = SetW'(SETTLE - 1);
            state_d  = StSettle;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StSettle: begin
        if (settle_q == '0) begin
          count_d = tree_count;
          vote_d  = tree_vote;
          valid_d = 1'b1;
          state_d = StOut;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      StOut: begin
        if (m_ready) begin
          valid_d = 1'b0;
          beat_d  = '0;
          state_d = StFill;
        end
      end
      default: begin
        valid_d = 1'b0;
        beat_d  = '0;
        state_d = StFill;
      end
    endcase
    // Registered so that s_ready only rises on the edge after reset release.
    ready_d = (state_d == StFill);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFill;
      beat_q   <= '0;
      shift_q  <= '0;
      settle_q <= '0;
      feat_q   <= '0;
      vote_q   <= 1'b0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      shift_q  <= shift_d;
      settle_q <= settle_d;
      feat_q   <= feat_d;
      vote_q   <= vote_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign s_ready = ready_q;
  assign feat_o  = feat_q;
  assign m_vote  = vote_q;
  assign m_count = count_q;
  assign m_valid = valid_q;
  assign busy    = (state_q == StSettle) || (state_q == StOut) ||
                   ((state_q == StFill) && (beat_q != '0));

endmodule

// File: tb/tb_tree_feature_loader.sv
// Directed bench for tree_feature_loader: vector table plus hand-written corner sequences.
module tb_tree_feature_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [50:0] feat_o;
  logic [4:0]  tree_i;
  logic        m_vote;
  logic [2:0]  m_count;
  logic        m_valid;
  logic        m_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  tree_feature_loader dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .feat_o (feat_o),
    .tree_i (tree_i),
    .m_vote (m_vote),
    .m_count(m_count),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .busy   (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [55:0] bytes;
    bit          gap;
    logic [4:0]  tree;
    logic [50:0] feat;
    logic [2:0]  cnt;
    logic        vote;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offers nbeats bytes (byte k at b[k*8+:8]); with gap, valid follows 1,0,0,1,0,0,...
  task automatic send_vec(input logic [55:0] b, input int nbeats, input bit gap,
                          output int first_cyc, output int acc_cyc);
    int   idx;
    int   guard;
    int   ph;
    logic will;
    idx = 0; guard = 0; ph = 0; first_cyc = -1;
    @(negedge clk);
    while (idx < nbeats && guard < 300) begin
      s_valid = gap ? (ph % 3 == 0) : 1'b1;
      s_data  = s_valid ? b[idx*8 +: 8] : 8'hEE;
      ph++;
      will = s_valid & s_ready;
      @(negedge clk);
      guard++;
      if (will) begin
        if (idx == 0) first_cyc = cyc;
        idx++;
      end
    end
    s_valid = 1'b0;
    acc_cyc = cyc;
    chk("beats_accepted", 64'(idx), 64'(nbeats));
  endtask

  task automatic wait_valid(output int vcyc);
    int g;
    g = 0;
    while (!m_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    vcyc = cyc;
    chk("m_valid_rise", 64'(m_valid), 64'd1);
  endtask

  task automatic take_result();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("m_valid_drop", 64'(m_valid), 64'd0);
    chk("s_ready_back", 64'(s_ready), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, first, vc, acc1, first1, acc2, first2;

    vecs[0] = '{56'h07FFFFFFFFFFFF, 1'b0, 5'b10110, 51'h7FFFFFFFFFFFF, 3'd3, 1'b1};
    vecs[1] = '{56'hFF000000000000, 1'b0, 5'b00000, 51'h7000000000000, 3'd0, 1'b0};
    vecs[2] = '{56'h07060504030201, 1'b1, 5'b11111, 51'h7060504030201, 3'd5, 1'b1};
    vecs[3] = '{56'hFAF00FC33C5AA5, 1'b0, 5'b00011, 51'h2F00FC33C5AA5, 3'd2, 1'b0};
    vecs[4] = '{56'hDEBC9A78563412, 1'b1, 5'b01110, 51'h6BC9A78563412, 3'd3, 1'b1};
    vecs[5] = '{56'h00000000000000, 1'b0, 5'b00001, 51'h0000000000000, 3'd1, 1'b0};

    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0; tree_i = 5'b0;
    repeat (2) @(negedge clk);
    chk("rst_feat", 64'(feat_o), 64'd0);
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_count", 64'(m_count), 64'd0);
    chk("rst_vote", 64'(m_vote), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    #1 chk("s_ready_before_edge", 64'(s_ready), 64'd0);
    @(negedge clk);
    chk("s_ready_after_edge", 64'(s_ready), 64'd1);

    // All-ones vector: latency from last accept to m_valid is SETTLE.
    tree_i = 5'b10110;
    send_vec(56'h07FFFFFFFFFFFF, 7, 1'b0, first, acc);
    chk("ones_feat", 64'(feat_o), 64'h7FFFFFFFFFFFF);
    chk("ones_busy", 64'(busy), 64'd1);
    chk("ones_s_ready_low", 64'(s_ready), 64'd0);
    chk("ones_no_early_valid", 64'(m_valid), 64'd0);
    wait_valid(vc);
    chk("ones_latency", 64'(vc - acc), 64'd2);
    chk("ones_count", 64'(m_count), 64'd3);
    chk("ones_vote", 64'(m_vote), 64'd1);
    take_result();
    chk("ones_feat_retained", 64'(feat_o), 64'h7FFFFFFFFFFFF);

    for (int i = 0; i < 6; i++) begin
      tree_i = vecs[i].tree;
      send_vec(vecs[i].bytes, 7, vecs[i].gap, first, acc);
      chk($sformatf("vec%0d_feat", i), 64'(feat_o), 64'(vecs[i].feat));
      wait_valid(vc);
      chk($sformatf("vec%0d_count", i), 64'(m_count), 64'(vecs[i].cnt));
      chk($sformatf("vec%0d_vote", i), 64'(m_vote), 64'(vecs[i].vote));
      take_result();
    end

    // Result must hold through backpressure while tree_i changes.
    tree_i = 5'b00011;
    send_vec(56'h70605040302010, 7, 1'b0, first, acc);
    chk("hold_feat", 64'(feat_o), 64'h6050403020 << 8 | 64'h10);
    wait_valid(vc);
    tree_i = 5'b11111;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hold%0d_valid", i), 64'(m_valid), 64'd1);
      chk($sformatf("hold%0d_count", i), 64'(m_count), 64'd2);
      chk($sformatf("hold%0d_vote", i), 64'(m_vote), 64'd0);
      chk($sformatf("hold%0d_s_ready", i), 64'(s_ready), 64'd0);
      @(negedge clk);
    end
    take_result();

    // Reset after three beats drops the partial vector and all outputs.
    tree_i = 5'b11100;
    send_vec(56'hAABBCCDDEEFF99, 3, 1'b0, first, acc);
    chk("partial_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_feat", 64'(feat_o), 64'd0);
    chk("midrst_count", 64'(m_count), 64'd0);
    chk("midrst_vote", 64'(m_vote), 64'd0);
    chk("midrst_valid", 64'(m_valid), 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_vec(56'h77665544332211, 7, 1'b0, first, acc);
    chk("postrst_feat", 64'(feat_o), 64'h7665544332211);
    wait_valid(vc);
    chk("postrst_count", 64'(m_count), 64'd3);
    chk("postrst_vote", 64'(m_vote), 64'd1);
    take_result();

    // Back-to-back vectors with m_ready held high.
    tree_i = 5'b00111;
    m_ready = 1'b1;
    send_vec(56'h01020304050607, 7, 1'b0, first1, acc1);
    send_vec(56'h05A5A5A5A5A5A5, 7, 1'b0, first2, acc2);
    chk("b2b_first_beat", 64'(first2 - acc1), 64'd4);
    chk("b2b_period", 64'(acc2 - acc1), 64'd10);
    chk("b2b_feat", 64'(feat_o), 64'h5A5A5A5A5A5A5);
    wait_valid(vc);
    chk("b2b_count", 64'(m_count), 64'd3);
    chk("b2b_vote", 64'(m_vote), 64'd1);
    @(negedge clk);
    chk("b2b_taken", 64'(m_valid), 64'd0);
    m_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
